// File: rtl/cosim_stim_sequencer.sv
// ----------------------------------------------------------------------------
// cosim_stim_sequencer
//
// Stimulus-and-check sequencer for a golden / post-synthesis DUT pair.
// It replays a fixed co-simulation sequence in hardware so the same check can
// run on emulation or FPGA. The sequence is:
//   RST1 -> GAP1 -> RAND (NUM_RANDOM LFSR vectors) -> RST2 -> GAP2 -> DIR
// It ends in DONE, where the statistics and the pass flag are held.
//
// Ports
//   clk              system clock, rising edge
//   rst              asynchronous active-low reset
//   start            begin a sequence (accepted only in IDLE or DONE)
//   dut_rst          active-high reset driven to both DUTs
//   stim             stimulus driven to both DUTs
//   golden           golden DUT output
//   netlist          post-synthesis DUT output
//   cmp_strobe       high in the cycle whose closing edge samples the compare
//   busy             sequence in progress (RST1..DIR)
//   done             sequence complete, held until the next start
//   pass             valid with done; 1 when no compare mismatched
//   vec_cnt          number of compares performed
//   mismatch_cnt     number of mismatching compares, saturating
//   first_mm_idx     vec_cnt value at the first mismatch
//   first_mm_golden  golden value captured at the first mismatch
//   first_mm_netlist netlist value captured at the first mismatch
// ----------------------------------------------------------------------------
module cosim_stim_sequencer #(
    parameter int          WIDTH      = 32,
    parameter int          NUM_RANDOM = 1000,
    parameter int          HOLD       = 2,
    parameter logic [31:0] SEED       = 32'h00000001,
    parameter logic [31:0] DIRECTED   = 32'hABCDEFAB,
    parameter int          CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             dut_rst,
    output logic [WIDTH-1:0] stim,
    input  logic [WIDTH-1:0] golden,
    input  logic [WIDTH-1:0] netlist,
    output logic             cmp_strobe,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [CNT_W-1:0] first_mm_idx,
    output logic [WIDTH-1:0] first_mm_golden,
    output logic [WIDTH-1:0] first_mm_netlist
);

    localparam logic [31:0] TAPS     = 32'h80200003;
    // An all-zero seed would lock the LFSR at zero.
    localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;
    localparam int          HOLD_W   = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam int          RCNT_W   = (NUM_RANDOM > 1) ? $clog2(NUM_RANDOM) : 1;

    typedef enum logic [2:0] {
        IDLE, RST1, GAP1, RAND, RST2, GAP2, DIR, DONE
    } state_t;

    state_t              state, state_nxt;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [RCNT_W-1:0]   rand_cnt;
    logic [31:0]         lfsr;
    logic                cmp_phase;
    logic                hold_last;
    logic                cmp;
    logic                start_ok;
    logic                mismatch;

    function automatic logic [31:0] lfsr_next(input logic [31:0] l);
        return (l >> 1) ^ (l[0] ? TAPS : 32'h0);
    endfunction

    assign cmp_phase = (state == RST1) || (state == RAND) ||
                       (state == RST2) || (state == DIR);
    assign hold_last = (hold_cnt == HOLD_W'(HOLD - 1));
    assign cmp       = cmp_phase && hold_last;
    assign start_ok  = start && ((state == IDLE) || (state == DONE));
    assign mismatch  = (golden != netlist);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= IDLE;
            hold_cnt         <= '0;
            rand_cnt         <= '0;
            lfsr             <= SEED_EFF;
            vec_cnt          <= '0;
            mismatch_cnt     <= '0;
            first_mm_idx     <= '0;
            first_mm_golden  <= '0;
            first_mm_netlist <= '0;
        end else begin
            state <= state_nxt;

            if (cmp_phase && !hold_last)
                hold_cnt <= hold_cnt + HOLD_W'(1);
            else
                hold_cnt <= '0;

            if (start_ok) begin
                rand_cnt         <= '0;
                lfsr             <= SEED_EFF;
                vec_cnt          <= '0;
                mismatch_cnt     <= '0;
                first_mm_idx     <= '0;
                first_mm_golden  <= '0;
                first_mm_netlist <= '0;
            end

            if (cmp) begin
                vec_cnt <= vec_cnt + CNT_W'(1);
                if (mismatch) begin
                    // Saturation never returns to zero, so zero means "no mismatch yet".
                    if (mismatch_cnt == '0) begin
                        first_mm_idx     <= vec_cnt;
                        first_mm_golden  <= golden;
                        first_mm_netlist <= netlist;
                    end
                    if (mismatch_cnt != {CNT_W{1'b1}})
                        mismatch_cnt <= mismatch_cnt + CNT_W'(1);
                end
                if (state == RAND) begin
                    lfsr     <= lfsr_next(lfsr);
                    rand_cnt <= rand_cnt + RCNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        dut_rst    = 1'b1;
        stim       = '0;
        busy       = 1'b0;
        done       = 1'b0;
        cmp_strobe = cmp;
        case (state)
            IDLE: if (start) state_nxt = RST1;
            RST1: begin
                busy = 1'b1;
                if (cmp) state_nxt = GAP1;
            end
            GAP1: begin
                busy      = 1'b1;
                dut_rst   = 1'b0;
                state_nxt = RAND;
            end
            RAND: begin
                busy    = 1'b1;
                dut_rst = 1'b0;
                stim    = lfsr[WIDTH-1:0];
                if (cmp && (rand_cnt == RCNT_W'(NUM_RANDOM - 1))) state_nxt = RST2;
            end
            RST2: begin
                busy = 1'b1;
                if (cmp) state_nxt = GAP2;
            end
            GAP2: begin
                busy      = 1'b1;
                dut_rst   = 1'b0;
                state_nxt = DIR;
            end
            DIR: begin
                busy    = 1'b1;
                dut_rst = 1'b0;
                stim    = DIRECTED[WIDTH-1:0];
                if (cmp) state_nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) state_nxt = RST1;
            end
            default: state_nxt = IDLE;
        endcase
        pass = done && (mismatch_cnt == '0);
    end

endmodule

// File: tb/tb_cosim_stim_sequencer.sv
// ----------------------------------------------------------------------------
// tb_cosim_stim_sequencer
//
// Directed bench for cosim_stim_sequencer. Instance "a" uses a 16-bit counter
// width and a switchable fault model on its netlist input; instance "b" uses a
// 2-bit counter width with an always-inverted netlist so saturation and wrap
// show up within a short sequence.
// ----------------------------------------------------------------------------
module tb_cosim_stim_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // Instance a
    logic        start_a = 1'b0;
    logic        dut_rst_a, cmp_strobe_a, busy_a, done_a, pass_a;
    logic [31:0] stim_a, golden_a, netlist_a;
    logic [15:0] vec_cnt_a, mismatch_cnt_a, first_mm_idx_a;
    logic [31:0] first_mm_golden_a, first_mm_netlist_a;
    logic        mm_mode = 1'b0;

    assign golden_a  = stim_a ^ 32'h12340000;
    assign netlist_a = (mm_mode && !dut_rst_a && (stim_a != 32'h0)) ? (golden_a ^ 32'h1) : golden_a;

    cosim_stim_sequencer #(
        .WIDTH(32), .NUM_RANDOM(4), .HOLD(2), .SEED(32'h00000001),
        .DIRECTED(32'hABCDEFAB), .CNT_W(16)
    ) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .dut_rst(dut_rst_a), .stim(stim_a),
        .golden(golden_a), .netlist(netlist_a), .cmp_strobe(cmp_strobe_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .vec_cnt(vec_cnt_a),
        .mismatch_cnt(mismatch_cnt_a), .first_mm_idx(first_mm_idx_a),
        .first_mm_golden(first_mm_golden_a), .first_mm_netlist(first_mm_netlist_a)
    );

    // Instance b
    logic        start_b = 1'b0;
    logic        dut_rst_b, cmp_strobe_b, busy_b, done_b, pass_b;
    logic [31:0] stim_b, golden_b, netlist_b;
    logic [1:0]  vec_cnt_b, mismatch_cnt_b, first_mm_idx_b;
    logic [31:0] first_mm_golden_b, first_mm_netlist_b;

    assign golden_b  = stim_b ^ 32'h12340000;
    assign netlist_b = ~golden_b;

    cosim_stim_sequencer #(
        .WIDTH(32), .NUM_RANDOM(4), .HOLD(2), .SEED(32'h00000001),
        .DIRECTED(32'hABCDEFAB), .CNT_W(2)
    ) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .dut_rst(dut_rst_b), .stim(stim_b),
        .golden(golden_b), .netlist(netlist_b), .cmp_strobe(cmp_strobe_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .vec_cnt(vec_cnt_b),
        .mismatch_cnt(mismatch_cnt_b), .first_mm_idx(first_mm_idx_b),
        .first_mm_golden(first_mm_golden_b), .first_mm_netlist(first_mm_netlist_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Per-cycle expectation for one busy window (HOLD=2, NUM_RANDOM=4, SEED=1).
    logic [31:0] exp_stim [16] = '{
        32'h0, 32'h0, 32'h0,
        32'h00000001, 32'h00000001, 32'h80200003, 32'h80200003,
        32'hC0300002, 32'hC0300002, 32'h60180001, 32'h60180001,
        32'h0, 32'h0, 32'h0,
        32'hABCDEFAB, 32'hABCDEFAB
    };
    logic exp_rst [16] = '{1,1,0, 0,0,0,0,0,0,0,0, 1,1,0, 0,0};
    logic exp_stb [16] = '{0,1,0, 0,1,0,1,0,1,0,1, 0,1,0, 0,1};

    task automatic check_idle_a(input string tag);
        check({tag, "_dut_rst"}, 32'(dut_rst_a), 32'h1);
        check({tag, "_stim"}, stim_a, 32'h0);
        check({tag, "_strobe"}, 32'(cmp_strobe_a), 32'h0);
        check({tag, "_busy"}, 32'(busy_a), 32'h0);
        check({tag, "_done"}, 32'(done_a), 32'h0);
        check({tag, "_pass"}, 32'(pass_a), 32'h0);
        check({tag, "_vec"}, 32'(vec_cnt_a), 32'h0);
        check({tag, "_mm"}, 32'(mismatch_cnt_a), 32'h0);
        check({tag, "_fidx"}, 32'(first_mm_idx_a), 32'h0);
        check({tag, "_fgold"}, first_mm_golden_a, 32'h0);
        check({tag, "_fnet"}, first_mm_netlist_a, 32'h0);
    endtask

    // Pulse start on instance a, walk the busy window cycle by cycle and
    // compare it against the table, then check the held results.
    task automatic run_seq_a(input string tag, input logic [31:0] exp_mm, input logic exp_pass);
        int n;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        n = 0;
        while (busy_a && n < 40) begin
            if (n < 16) begin
                check($sformatf("%s_stim_c%0d", tag, n), stim_a, exp_stim[n]);
                check($sformatf("%s_drst_c%0d", tag, n), 32'(dut_rst_a), 32'(exp_rst[n]));
                check($sformatf("%s_stb_c%0d", tag, n), 32'(cmp_strobe_a), 32'(exp_stb[n]));
            end
            n++;
            @(negedge clk);
        end
        check({tag, "_busy_len"}, 32'(n), 32'd16);
        check({tag, "_done"}, 32'(done_a), 32'h1);
        check({tag, "_busy_off"}, 32'(busy_a), 32'h0);
        check({tag, "_vec"}, 32'(vec_cnt_a), 32'd7);
        check({tag, "_mm"}, 32'(mismatch_cnt_a), exp_mm);
        check({tag, "_pass"}, 32'(pass_a), 32'(exp_pass));
        check({tag, "_done_stim"}, stim_a, 32'h0);
        check({tag, "_done_drst"}, 32'(dut_rst_a), 32'h1);
    endtask

    initial begin
        int  n;
        bit  found;
        bit  pulsed;

        // Reset state
        #12;
        check_idle_a("reset");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_idle_a("idle");

        // Clean run: random/directed stimulus, strobes, counts, pass
        mm_mode = 1'b0;
        run_seq_a("clean", 32'd0, 1'b1);
        check("clean_fidx", 32'(first_mm_idx_a), 32'h0);

        // Faulty netlist on every non-zero, out-of-reset vector
        mm_mode = 1'b1;
        run_seq_a("fault", 32'd5, 1'b0);
        check("fault_fidx", 32'(first_mm_idx_a), 32'd1);
        check("fault_fgold", first_mm_golden_a, 32'h12340001);
        check("fault_fnet", first_mm_netlist_a, 32'h12340000);
        check("fault_fnet_rel", first_mm_netlist_a, first_mm_golden_a ^ 32'h1);

        // Reset in the middle of the 3rd random vector
        mm_mode = 1'b0;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        found = 1'b0;
        n = 0;
        while (!found && n < 40) begin
            if (stim_a == 32'hC0300002) found = 1'b1;
            else begin
                n++;
                @(negedge clk);
            end
        end
        check("abort_reached_rand3", 32'(found), 32'h1);
        check("abort_vec_before", 32'(vec_cnt_a), 32'd3);
        #2 rst = 1'b0;
        #1;
        check_idle_a("abort");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_seq_a("replay", 32'd0, 1'b1);

        // Saturation, counter wrap, and start ignored while busy (instance b)
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        n = 0;
        pulsed = 1'b0;
        while (busy_b && n < 40) begin
            if (!pulsed && stim_b == 32'h80200003) begin
                start_b = 1'b1;
                pulsed  = 1'b1;
            end else begin
                start_b = 1'b0;
            end
            n++;
            @(negedge clk);
        end
        start_b = 1'b0;
        check("sat_start_seen", 32'(pulsed), 32'h1);
        check("sat_busy_len", 32'(n), 32'd16);
        check("sat_done", 32'(done_b), 32'h1);
        check("sat_vec_wrap", 32'(vec_cnt_b), 32'd3);
        check("sat_mm", 32'(mismatch_cnt_b), 32'd3);
        check("sat_pass", 32'(pass_b), 32'h0);
        check("sat_fidx", 32'(first_mm_idx_b), 32'd0);
        check("sat_fgold", first_mm_golden_b, 32'h12340000);
        check("sat_fnet", first_mm_netlist_b, 32'hEDCBFFFF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cosim_stim_sequencer.md
Name: cosim_stim_sequencer

Overview:
Synthesizable stimulus-and-check sequencer that drives the input of a golden/post-synth DUT pair and compares their outputs. It replaces the behavioural co-sim bench sequence with RTL so the same check runs on emulation/FPGA: reset phase, N pseudo-random vectors, second reset phase, one directed vector. It sits directly upstream of the DUT pair (drives `rst`/`in`) and consumes both `out` buses, keeping mismatch statistics and a pass flag.

Parameters:
- WIDTH, 32, data width of stimulus and DUT outputs.
- NUM_RANDOM, 1000, number of LFSR vectors in the random phase (>=1).
- HOLD, 2, cycles each vector is held before its compare (>=1).
- SEED, 32'h00000001, LFSR load value; 0 is replaced by 1.
- DIRECTED, 32'hABCDEFAB, directed-phase vector.
- CNT_W, 16, width of counters and index outputs.

Ports:
- clk  in  1  single system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begin sequence; sampled in IDLE or DONE only.
- dut_rst  out  1  active-high reset driven to both DUTs.
- stim  out  WIDTH  stimulus to both DUTs.
- golden  in  WIDTH  golden DUT output.
- netlist  in  WIDTH  post-synth DUT output.
- cmp_strobe  out  1  high in the cycle whose closing edge performs a compare.
- busy  out  1  sequence in progress.
- done  out  1  sequence complete (level, held).
- pass  out  1  valid with done; 1 iff mismatch_cnt==0.
- vec_cnt  out  CNT_W  number of compares performed.
- mismatch_cnt  out  CNT_W  mismatching compares, saturating.
- first_mm_idx  out  CNT_W  vec_cnt value at first mismatch.
- first_mm_golden  out  WIDTH  golden value at first mismatch.
- first_mm_netlist  out  WIDTH  netlist value at first mismatch.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. Ports are `clk` and `rst`.
- Reset (`rst`=0, immediate): state IDLE; dut_rst=1; all other outputs 0; LFSR=SEED.
- States: IDLE, RST1, GAP1, RAND, RST2, GAP2, DIR, DONE.
- IDLE/DONE, start=1:
  - clear counters and captures; load LFSR; done=0; go to RST1 next cycle.
- start while busy is ignored.
- RST1/RST2: dut_rst=1, stim=0, held HOLD cycles, one compare each.
- GAP1/GAP2: dut_rst=0, stim=0, 1 cycle, no compare.
- RAND: dut_rst=0; stim=LFSR; each vector held HOLD cycles then compared.
  - LFSR advances at the compare edge.
  - Exit after NUM_RANDOM vectors.
- DIR: dut_rst=0, stim=DIRECTED, HOLD cycles, one compare; then DONE.
- DONE: done=1, busy=0, pass=(mismatch_cnt==0); stim=0, dut_rst=1.
- Compare timing:
  - Hold counter runs 0..HOLD-1; cmp_strobe=1 when counter==HOLD-1.
  - golden/netlist are sampled at the closing edge of that cycle.
- Compare update:
  - vec_cnt increments every compare.
  - Mismatch is golden != netlist. On mismatch, mismatch_cnt increments and saturates at all-ones.
  - Only the first mismatch loads first_mm_* (idx = vec_cnt before increment).
- Busy length: HOLD*(NUM_RANDOM+3)+2 cycles; total compares NUM_RANDOM+3.
- LFSR: Galois, right shift, taps 32'h80200003 (x^32+x^22+x^2+x+1).
  - next = (l>>1) ^ (l[0] ? 32'h80200003 : 0).
  - First random vector = SEED. For WIDTH≠32 use the LFSR low WIDTH bits (WIDTH≤32).
- busy=1 in RST1..DIR. done and busy are never both 1.
- Reset mid-sequence aborts with no partial results; a later start replays the identical sequence.

Test Plan:
1. NUM_RANDOM=4, HOLD=2, netlist=golden, start pulse -> busy 16 cycles; vec_cnt=7; mismatch_cnt=0; done=1, pass=1.
2. SEED=1, observe stim in RAND -> 0x00000001, 0x80200003, 0xC0300002, ... with dut_rst=0; cmp_strobe every 2nd cycle.
3. netlist=golden^1 only while dut_rst=0 and stim≠0 (NUM_RANDOM=4) -> mismatch_cnt=5 (4 random + directed); first_mm_idx=1; first_mm_netlist=first_mm_golden^1; pass=0.
4. DIR phase -> stim=0xABCDEFAB for 2 cycles with dut_rst=0; compare is 7th (vec_cnt 6->7); preceded by RST2 (dut_rst=1, stim=0, 2 cycles) and GAP2.
5. rst low during 3rd random vector -> same cycle dut_rst=1 and all other outputs 0. After release plus start -> stim sequence restarts at SEED, counts from 0.
6. CNT_W=2, netlist=~golden, NUM_RANDOM=4 -> mismatch_cnt saturates at 3. A start pulse mid-RAND does not restart; vec_cnt still reaches 7 (wraps to 3 at CNT_W=2, noted as expected).
